// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32 execution-side types.
//   - mdu_op_e      : MDU opcode encodings (mdu_op_*), 3 bits
//   - MDU_TAG_W     : ROB/physical tag width used by the MDU datapath
//   - mdu_issue_t   : one issued MDU op {opc, src1, src2, tag}
//   - mdu_op_is_mul : classifies an opcode as mul-class (mul/mulh/mulhsu/mulhu)
package rv32i_types;

  localparam int MDU_TAG_W = 4;

  typedef enum logic [2:0] {
    mdu_op_mul    = 3'd0,
    mdu_op_mulh   = 3'd1,
    mdu_op_mulhsu = 3'd2,
    mdu_op_mulhu  = 3'd3,
    mdu_op_div    = 3'd4,
    mdu_op_divu   = 3'd5,
    mdu_op_rem    = 3'd6,
    mdu_op_remu   = 3'd7
  } mdu_op_e;

  typedef struct packed {
    logic [2:0]           opc;
    logic [31:0]          src1;
    logic [31:0]          src2;
    logic [MDU_TAG_W-1:0] tag;
  } mdu_issue_t;

  function automatic logic mdu_op_is_mul(input logic [2:0] opc);
    return (opc == mdu_op_mul)    || (opc == mdu_op_mulh) ||
           (opc == mdu_op_mulhsu) || (opc == mdu_op_mulhu);
  endfunction

endpackage

// File: rtl/mdu_issue_arb_if.sv
// rvs2exu_itf: reservation-station -> execution-unit issue handshake.
//   req  : op valid (issuer)        opc/src1/src2/tag : op payload (issuer)
//   rdy  : unit accepts the op this cycle (execution unit)
// Modports: rvs (issuer side), exu (execution-unit side).
interface rvs2exu_itf #(
  parameter int TAG_W = 4
) ();
  logic             req;
  logic [2:0]       opc;
  logic [31:0]      src1;
  logic [31:0]      src2;
  logic [TAG_W-1:0] tag;
  logic             rdy;

  modport rvs (output req, opc, src1, src2, tag, input rdy);
  modport exu (input req, opc, src1, src2, tag, output rdy);
endinterface

// File: rtl/mdu_issue_arb_rr_pick.sv
// rr_pick: round-robin one-hot picker.
//   vld [N]  : candidate requests
//   ptr      : highest-priority index this cycle
//   gnt [N]  : one-hot, first set vld at or after ptr (wrapping)
//   any      : at least one candidate
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vld,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 any
);
  localparam int PW = $clog2(N);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && vld[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |vld;
endmodule

// File: rtl/mdu_issue_arb.sv
// mdu_issue_arb: shares the single MDU among NUM_REQ reservation stations.
// Round-robin picks at most one ready request per cycle into a one-entry
// issue register which drives the MDU handshake.
// Ports:
//   clk, rst_n (async, active-low), flush (drops the issue register)
//   req_vld/req_opc/req_src1/req_src2/req_tag : per-requester op
//   req_gnt : one-hot, combinational capture strobe back to requesters
//   mdu_itf : rvs2exu_itf.rvs toward the MDU
// Config macro MDU_ARB_MUL_PRIO_EN: mul-class ops win over div-class ops,
// with div forced after STARVE_MAX consecutive mul-over-div grants.
module mdu_issue_arb
  import rv32i_types::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int TAG_W      = MDU_TAG_W,
  parameter int STARVE_MAX = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_vld,
  input  logic [NUM_REQ-1:0][2:0]         req_opc,
  input  logic [NUM_REQ-1:0][31:0]        req_src1,
  input  logic [NUM_REQ-1:0][31:0]        req_src2,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  output logic [NUM_REQ-1:0]              req_gnt,
  rvs2exu_itf.rvs                         mdu_itf
);
  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_chk_req
    $error("mdu_issue_arb: NUM_REQ must be >= 2");
  end
  if (TAG_W != MDU_TAG_W) begin : g_chk_tag
    $error("mdu_issue_arb: TAG_W must match the MDU tag width");
  end
  if (STARVE_MAX < 1) begin : g_chk_starve
    $error("mdu_issue_arb: STARVE_MAX must be >= 1");
  end

  mdu_issue_t         issue_q;
  mdu_issue_t         win;
  logic               out_vld;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      rr_nxt;
  logic [NUM_REQ-1:0] arb_vld;
  logic [NUM_REQ-1:0] pick_gnt;
  logic               pick_any;
  logic               load_ok;
  logic               gnt_en;
  logic               do_gnt;

  // A full register can only be replaced in the cycle the MDU takes it.
  assign load_ok = !out_vld || mdu_itf.rdy;
  assign gnt_en  = load_ok && !flush;
  assign do_gnt  = gnt_en && pick_any;
  assign req_gnt = gnt_en ? pick_gnt : '0;

`ifdef MDU_ARB_MUL_PRIO_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0]      starve_cnt;
  logic [NUM_REQ-1:0] mul_vec;
  logic [NUM_REQ-1:0] div_vec;
  logic               mul_pend;
  logic               div_pend;

  always_comb begin
    mul_vec = '0;
    for (int i = 0; i < NUM_REQ; i++)
      mul_vec[i] = req_vld[i] && mdu_op_is_mul(req_opc[i]);
  end
  assign div_vec  = req_vld & ~mul_vec;
  assign mul_pend = |mul_vec;
  assign div_pend = |div_vec;

  // Starvation guard overrides mul priority; with only one class pending
  // the full request vector competes so nothing stalls.
  always_comb begin
    arb_vld = req_vld;
    if (starve_cnt == SW'(STARVE_MAX) && div_pend) arb_vld = div_vec;
    else if (mul_pend && div_pend)                 arb_vld = mul_vec;
  end

  // Counts mul grants taken while a div was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (do_gnt) begin
      if (!mdu_op_is_mul(win.opc) || !div_pend) starve_cnt <= '0;
      else                                      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign arb_vld = req_vld;
`endif

  rr_pick #(.N(NUM_REQ)) u_pick (
    .vld (arb_vld),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );

  // One-hot -> index and payload mux of the winner.
  always_comb begin
    win_idx = '0;
    win     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        win_idx  = PW'(i);
        win.opc  = req_opc[i];
        win.src1 = req_src1[i];
        win.src2 = req_src2[i];
        win.tag  = req_tag[i];
      end
    end
  end

  assign rr_nxt = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      issue_q <= '0;
      rr_ptr  <= '0;
    end else begin
      if (flush) begin
        out_vld <= 1'b0;
      end else if (do_gnt) begin
        out_vld <= 1'b1;
        issue_q <= win;
        rr_ptr  <= rr_nxt;
      end else if (mdu_itf.rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign mdu_itf.req  = out_vld;
  assign mdu_itf.opc  = issue_q.opc;
  assign mdu_itf.src1 = issue_q.src1;
  assign mdu_itf.src2 = issue_q.src2;
  assign mdu_itf.tag  = issue_q.tag;
endmodule

// File: tb/tb_mdu_issue_arb.sv
// tb_mdu_issue_arb: directed scenarios plus randomized traffic for
// mdu_issue_arb, checked against a transaction-level reference model.
module tb_mdu_issue_arb;
  localparam int N    = 4;
  localparam int TW   = 4;
  localparam int SMAX = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush;
  logic [N-1:0]         req_vld;
  logic [N-1:0][2:0]    req_opc;
  logic [N-1:0][31:0]   req_src1;
  logic [N-1:0][31:0]   req_src2;
  logic [N-1:0][TW-1:0] req_tag;
  logic [N-1:0]         req_gnt;

  rvs2exu_itf #(.TAG_W(TW)) mdu_itf ();

  mdu_issue_arb #(.NUM_REQ(N), .TAG_W(TW), .STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .req_vld  (req_vld),
    .req_opc  (req_opc),
    .req_src1 (req_src1),
    .req_src2 (req_src2),
    .req_tag  (req_tag),
    .req_gnt  (req_gnt),
    .mdu_itf  (mdu_itf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what the issue slot holds and who is next in line.
  bit          m_vld;
  logic [2:0]  m_opc;
  logic [31:0] m_s1, m_s2;
  logic [TW-1:0] m_tag;
  int          m_ptr;
  int          m_starve;

  function automatic bit is_mul(input logic [2:0] o);
    return o < 3'd4;
  endfunction

  // Who should win among the current requesters, -1 if nobody.
  function automatic int model_pick();
    logic [N-1:0] elig;
    elig = req_vld;
`ifdef MDU_ARB_MUL_PRIO_EN
    begin
      logic [N-1:0] mulv, divv;
      mulv = '0; divv = '0;
      for (int i = 0; i < N; i++)
        if (req_vld[i]) begin
          if (is_mul(req_opc[i])) mulv[i] = 1'b1;
          else                    divv[i] = 1'b1;
        end
      if (m_starve == SMAX && divv != 0)  elig = divv;
      else if (mulv != 0 && divv != 0)   elig = mulv;
    end
`endif
    for (int k = 0; k < N; k++)
      if (elig[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_gnt();
    logic [N-1:0] g;
    int w;
    g = '0;
    if (flush || (m_vld && !mdu_itf.rdy)) return g;
    w = model_pick();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  // Advance one clock; model consumes the inputs present before the edge.
  task automatic tick(output int w);
    bit lok, fl, rdy, divp;
    lok  = !m_vld || mdu_itf.rdy;
    fl   = flush;
    rdy  = mdu_itf.rdy;
    w    = (lok && !fl) ? model_pick() : -1;
    divp = 1'b0;
    for (int i = 0; i < N; i++)
      if (req_vld[i] && !is_mul(req_opc[i])) divp = 1'b1;
    if (w >= 0) begin
`ifdef MDU_ARB_MUL_PRIO_EN
      if (!is_mul(req_opc[w]) || !divp) m_starve = 0;
      else                              m_starve = m_starve + 1;
`endif
    end
    @(posedge clk);
    if (fl) m_vld = 1'b0;
    else if (w >= 0) begin
      m_vld = 1'b1; m_opc = req_opc[w]; m_s1 = req_src1[w];
      m_s2 = req_src2[w]; m_tag = req_tag[w]; m_ptr = (w + 1) % N;
    end else if (m_vld && rdy) m_vld = 1'b0;
    #1;
  endtask

  task automatic model_clear();
    m_vld = 0; m_opc = 0; m_s1 = 0; m_s2 = 0; m_tag = 0; m_ptr = 0; m_starve = 0;
  endtask

  task automatic do_reset();
    flush = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    #1;
  endtask

  task automatic set_fields();
    for (int i = 0; i < N; i++) begin
      req_opc[i]  = 3'(i);
      req_src1[i] = 32'h1000_0000 + 32'(i);
      req_src2[i] = 32'h2000_0000 + 32'(i);
      req_tag[i]  = TW'(i + 8);
    end
  endtask

  task automatic test_reset();
    int w;
    set_fields();
    flush = 1'b0; req_vld = 4'b1111; mdu_itf.rdy = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mdu_itf.req !== 1'b0 || mdu_itf.tag !== '0 || mdu_itf.src1 !== '0) begin
      errors++; $display("FAIL reset_state: req=%b tag=%h src1=%h exp 0", mdu_itf.req, mdu_itf.tag, mdu_itf.src1);
    end
    rst_n = 1'b1;
    model_clear();
    #1;
    checks++;
    if (req_gnt !== 4'b0001) begin
      errors++; $display("FAIL reset_first_gnt: got %b exp 0001", req_gnt);
    end
    tick(w);
    checks++;
    if (mdu_itf.req !== 1'b1 || mdu_itf.tag !== req_tag[0]) begin
      errors++; $display("FAIL reset_first_issue: req=%b tag=%h exp 1/%h", mdu_itf.req, mdu_itf.tag, req_tag[0]);
    end
  endtask

  task automatic test_rotation();
    int w;
    do_reset();
    set_fields(); req_vld = 4'b1111; mdu_itf.rdy = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] e;
      e = '0; e[k % N] = 1'b1;
      checks++;
      if (req_gnt !== e) begin
        errors++; $display("FAIL rotation_gnt[%0d]: got %b exp %b", k, req_gnt, e);
      end
      if (k > 0) begin
        checks++;
        if (mdu_itf.req !== 1'b1 || mdu_itf.tag !== req_tag[(k - 1) % N]) begin
          errors++; $display("FAIL rotation_tag[%0d]: got %h exp %h", k, mdu_itf.tag, req_tag[(k - 1) % N]);
        end
      end
      tick(w);
    end
  endtask

  task automatic test_back_pressure();
    int w;
    logic [TW-1:0] tag_h;
    logic [31:0]   s1_h;
    // register is full after rotation
    mdu_itf.rdy = 1'b0;
    #1;
    tag_h = m_tag; s1_h = m_s1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_gnt !== '0 || mdu_itf.req !== 1'b1 || mdu_itf.tag !== tag_h || mdu_itf.src1 !== s1_h) begin
        errors++; $display("FAIL backpressure_hold[%0d]: gnt=%b req=%b tag=%h src1=%h exp 0000/1/%h/%h",
                           k, req_gnt, mdu_itf.req, mdu_itf.tag, mdu_itf.src1, tag_h, s1_h);
      end
      tick(w);
    end
    mdu_itf.rdy = 1'b1;
    #1;
    checks++;
    if (req_gnt === '0 || req_gnt !== model_gnt()) begin
      errors++; $display("FAIL backpressure_refill: got %b exp %b", req_gnt, model_gnt());
    end
    tick(w);
    checks++;
    if (w < 0 || mdu_itf.req !== 1'b1 || mdu_itf.tag !== req_tag[w < 0 ? 0 : w]) begin
      errors++; $display("FAIL backpressure_issue: req=%b tag=%h", mdu_itf.req, mdu_itf.tag);
    end
  endtask

  task automatic test_flush();
    int w;
    req_vld = 4'b1111; mdu_itf.rdy = 1'b1;
    tick(w);
    req_vld = 4'b0100; flush = 1'b1;
    #1;
    checks++;
    if (req_gnt !== 4'b0000) begin
      errors++; $display("FAIL flush_gnt: got %b exp 0000", req_gnt);
    end
    tick(w);
    flush = 1'b0;
    #1;
    checks++;
    if (mdu_itf.req !== 1'b0 || req_gnt !== 4'b0100) begin
      errors++; $display("FAIL flush_after: req=%b gnt=%b exp 0/0100", mdu_itf.req, req_gnt);
    end
    tick(w);
    checks++;
    if (mdu_itf.req !== 1'b1 || mdu_itf.tag !== req_tag[2]) begin
      errors++; $display("FAIL flush_reissue: req=%b tag=%h exp 1/%h", mdu_itf.req, mdu_itf.tag, req_tag[2]);
    end
  endtask

  task automatic test_async_reset();
    int w;
    do_reset();
    req_vld = 4'b0010; mdu_itf.rdy = 1'b1;
    tick(w);
    req_vld = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mdu_itf.req !== 1'b0 || mdu_itf.src1 !== '0) begin
      errors++; $display("FAIL async_reset: req=%b src1=%h exp 0/0", mdu_itf.req, mdu_itf.src1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    #1;
    checks++;
    if (mdu_itf.req !== 1'b0 || req_gnt !== 4'b0000) begin
      errors++; $display("FAIL async_reset_noreissue: req=%b gnt=%b", mdu_itf.req, req_gnt);
    end
    tick(w);
  endtask

  task automatic test_sparse_wrap();
    int w;
    do_reset();
    set_fields(); mdu_itf.rdy = 1'b1;
    req_vld = 4'b0001;
    tick(w);              // rr_ptr now 1
    req_vld = 4'b1001;
    #1;
    checks++;
    if (req_gnt !== 4'b1000) begin
      errors++; $display("FAIL sparse_first: got %b exp 1000", req_gnt);
    end
    tick(w);
    checks++;
    if (req_gnt !== 4'b0001) begin
      errors++; $display("FAIL sparse_wrap: got %b exp 0001", req_gnt);
    end
    tick(w);
    req_vld = 4'b0000;
    tick(w);
  endtask

  task automatic test_mul_prio();
    int w;
    int exp_w;
    do_reset();
    set_fields(); mdu_itf.rdy = 1'b1;
    req_opc[0] = 3'd0;   // mul
    req_opc[1] = 3'd4;   // div
    req_vld = 4'b0011;
    #1;
    for (int k = 0; k < 8; k++) begin
`ifdef MDU_ARB_MUL_PRIO_EN
      exp_w = (k % 4 == 3) ? 1 : 0;
`else
      exp_w = k % 2;
`endif
      checks++;
      if (req_gnt !== 4'(1 << exp_w)) begin
        errors++; $display("FAIL mul_prio[%0d]: got %b exp %b", k, req_gnt, 4'(1 << exp_w));
      end
      tick(w);
    end
    req_vld = '0;
    tick(w);
  endtask

  task automatic test_random();
    int w;
    logic [N-1:0] g;
    do_reset();
    req_vld = '0; mdu_itf.rdy = 1'b1;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_vld[i] && $urandom_range(0, 99) < 40) begin
          req_vld[i]  = 1'b1;
          req_opc[i]  = 3'($urandom_range(0, 7));
          req_src1[i] = $urandom;
          req_src2[i] = $urandom;
          req_tag[i]  = TW'($urandom_range(0, 15));
        end
      mdu_itf.rdy = ($urandom_range(0, 99) < 70);
      flush = ($urandom_range(0, 99) < 5);
      #1;
      g = model_gnt();
      checks++;
      if (req_gnt !== g || mdu_itf.req !== m_vld) begin
        errors++; $display("FAIL random_gnt[%0d]: gnt=%b req=%b exp %b/%b", c, req_gnt, mdu_itf.req, g, m_vld);
      end
      if (m_vld) begin
        checks++;
        if (mdu_itf.opc !== m_opc || mdu_itf.src1 !== m_s1 || mdu_itf.src2 !== m_s2 || mdu_itf.tag !== m_tag) begin
          errors++; $display("FAIL random_fields[%0d]: opc=%0d tag=%h src1=%h exp %0d/%h/%h",
                             c, mdu_itf.opc, mdu_itf.tag, mdu_itf.src1, m_opc, m_tag, m_s1);
        end
      end
      tick(w);
      if (w >= 0) req_vld[w] = 1'b0;   // granted requester retires its entry
    end
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_vld = '0; mdu_itf.rdy = 1'b0;
    req_opc = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
    model_clear();
    test_reset();
    test_rotation();
    test_back_pressure();
    test_flush();
    test_async_reset();
    test_sparse_wrap();
    test_mul_prio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
